fetch_resp_buffer: RTL and testbench

Tracks in-flight instruction-memory fetches between the F-stage PC logic and the D-stage instruction register. Tags each issued imem request with its PC and pairs in-order responses with those PCs. Silently drops responses belonging to fetches squashed by a redirect (branch/jump). Presents a clean {pc, inst} val/rdy stream to decode.

---
 rtl/fetch_resp_buffer_pkg.sv | 21 ++
 rtl/fetch_resp_buffer_if.sv | 30 +++
 rtl/fetch_resp_buffer_ptr.sv | 23 ++
 rtl/fetch_resp_buffer.sv | 109 ++++++++++
 tb/tb_fetch_resp_buffer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_resp_buffer_pkg.sv
// Shared types and sizing helpers for the fetch response buffer.
package fetch_resp_buffer_pkg;

    localparam int c_addr_nbits = 32;
    localparam int c_depth      = 2;

    function automatic int ptr_nbits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int c_ptr_nbits = ptr_nbits(c_depth);

    // Storage is sized for the widest supported PC; narrower builds use the low bits.
    typedef struct packed {
        logic [c_addr_nbits-1:0] pc;
        logic [c_addr_nbits-1:0] inst;
        logic                    data_val;
        logic                    squashed;
    } fetch_buf_entry_t;

endpackage

// File: rtl/fetch_resp_buffer_if.sv
// Fetch-issue, imem request/response and decode-output handshakes of the fetch buffer.
interface fetch_resp_buffer_if #(
    parameter int p_addr_nbits = 32
);
    logic                    fetch_val;
    logic                    fetch_rdy;
    logic [p_addr_nbits-1:0] fetch_pc;
    logic                    imemreq_val;
    logic                    imemreq_rdy;
    logic [p_addr_nbits-1:0] imemreq_addr;
    logic                    imemresp_val;
    logic                    imemresp_rdy;
    logic [p_addr_nbits-1:0] imemresp_data;
    logic                    squash;
    logic                    out_val;
    logic                    out_rdy;
    logic [p_addr_nbits-1:0] out_pc;
    logic [p_addr_nbits-1:0] out_inst;

    // Environment side: F-stage PC logic, instruction memory and D stage.
    modport master (
        output fetch_val, fetch_pc, imemreq_rdy, imemresp_val, imemresp_data, squash, out_rdy,
        input  fetch_rdy, imemreq_val, imemreq_addr, imemresp_rdy, out_val, out_pc, out_inst
    );

    modport slave (
        input  fetch_val, fetch_pc, imemreq_rdy, imemresp_val, imemresp_data, squash, out_rdy,
        output fetch_rdy, imemreq_val, imemreq_addr, imemresp_rdy, out_val, out_pc, out_inst
    );
endinterface

// File: rtl/fetch_resp_buffer_ptr.sv
// Ring pointer with enable; wraps to zero after p_depth-1.
module fetch_buf_ptr
    import fetch_resp_buffer_pkg::*;
#(
    parameter int p_depth = c_depth,
    parameter int p_nbits = c_ptr_nbits
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [p_nbits-1:0] ptr
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == p_nbits'(p_depth - 1)) ? '0 : ptr + p_nbits'(1);
        end
    end

endmodule

// File: rtl/fetch_resp_buffer.sv
// Pairs in-order imem responses with their fetch PCs and drops squashed fetches.
// Optional FETCH_RESP_BUFFER_BYPASS_EN: forward a response to decode in the same cycle.
module fetch_resp_buffer
    import fetch_resp_buffer_pkg::*;
#(
    parameter int p_depth      = c_depth,
    parameter int p_addr_nbits = c_addr_nbits
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_resp_buffer_if.slave   bus
);

    localparam int c_pw = ptr_nbits(p_depth);
    localparam int c_cw = c_pw + 1;

    fetch_buf_entry_t entries [p_depth];
    fetch_buf_entry_t head;
    logic [c_pw-1:0]  alloc_ptr;
    logic [c_pw-1:0]  resp_ptr;
    logic [c_pw-1:0]  head_ptr;
    logic [c_cw-1:0]  count;
    logic             not_full;
    logic             head_live;
    logic             awaiting;
    logic             fire;
    logic             resp_fire;
    logic             bypass;
    logic             write_resp;
    logic             retire;

    assign head      = entries[head_ptr];
    assign not_full  = count < c_cw'(p_depth);
    assign head_live = count != '0;
    // When full, resp==alloc is ambiguous; the slot's data flag tells waiting from done.
    assign awaiting  = (resp_ptr != alloc_ptr) || (!not_full && !entries[resp_ptr].data_val);

    assign bus.fetch_rdy     = reset && bus.imemreq_rdy && not_full;
    assign bus.imemreq_val   = reset && bus.fetch_val && not_full;
    assign bus.imemreq_addr  = bus.fetch_pc;
    assign bus.imemresp_rdy  = awaiting;
    assign bus.out_pc        = head.pc[p_addr_nbits-1:0];

    assign fire      = bus.fetch_val && bus.fetch_rdy;
    assign resp_fire = bus.imemresp_val && awaiting;

`ifdef FETCH_RESP_BUFFER_BYPASS_EN
    assign bypass = head_live && (head_ptr == resp_ptr) && !head.data_val && !head.squashed &&
                    bus.imemresp_val && !bus.squash;
    assign bus.out_val  = (head_live && head.data_val && !head.squashed && !bus.squash) || bypass;
    assign bus.out_inst = bypass ? bus.imemresp_data : head.inst[p_addr_nbits-1:0];
`else
    assign bypass       = 1'b0;
    assign bus.out_val  = head_live && head.data_val && !head.squashed && !bus.squash;
    assign bus.out_inst = head.inst[p_addr_nbits-1:0];
`endif

    // A bypassed response consumed by decode never lands in the buffer.
    assign write_resp = resp_fire && !(bypass && bus.out_rdy);
    assign retire     = head_live &&
                        ((head.data_val && (head.squashed || (bus.out_val && bus.out_rdy))) ||
                         (bypass && bus.out_rdy));

    fetch_buf_ptr #(.p_depth(p_depth), .p_nbits(c_pw)) u_alloc_ptr (
        .clk(clk), .reset(reset), .en(fire), .ptr(alloc_ptr)
    );

    fetch_buf_ptr #(.p_depth(p_depth), .p_nbits(c_pw)) u_resp_ptr (
        .clk(clk), .reset(reset), .en(resp_fire), .ptr(resp_ptr)
    );

    fetch_buf_ptr #(.p_depth(p_depth), .p_nbits(c_pw)) u_head_ptr (
        .clk(clk), .reset(reset), .en(retire), .ptr(head_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count + c_cw'(fire) - c_cw'(retire);
        end
    end

    // NOTE: the entry array is reset because out_pc/out_inst must read zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_depth; i++) begin
                entries[i] <= '0;
            end
        end else begin
            // Marking free slots is harmless: allocation clears the flag below.
            if (bus.squash) begin
                for (int i = 0; i < p_depth; i++) begin
                    entries[i].squashed <= 1'b1;
                end
            end
            if (write_resp) begin
                entries[resp_ptr].inst     <= c_addr_nbits'(bus.imemresp_data);
                entries[resp_ptr].data_val <= 1'b1;
            end
            if (fire) begin
                entries[alloc_ptr].pc       <= c_addr_nbits'(bus.fetch_pc);
                entries[alloc_ptr].data_val <= 1'b0;
                entries[alloc_ptr].squashed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_resp_buffer.sv
// Self-checking bench for fetch_resp_buffer: vector tables, directed corners, random vs queue model.
module tb_fetch_resp_buffer;

    localparam int c_depth = 2;
    localparam int c_nbits = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_resp_buffer_if #(.p_addr_nbits(c_nbits)) bus ();

    fetch_resp_buffer #(.p_depth(c_depth), .p_addr_nbits(c_nbits)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        mrdy;
        logic        rv;
        logic [31:0] rd;
        logic        sq;
        logic        ordy;
        logic        e_frdy;
        logic        e_ival;
        logic        e_rrdy;
        logic        e_oval;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          has_data;
        bit          sq;
    } ment_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic mrdy, input logic rv,
                         input logic [31:0] rd, input logic sq, input logic ordy);
        bus.fetch_val     = fv;
        bus.fetch_pc      = pc;
        bus.imemreq_rdy   = mrdy;
        bus.imemresp_val  = rv;
        bus.imemresp_data = rd;
        bus.squash        = sq;
        bus.out_rdy       = ordy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic fv, input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                       input logic sq, input logic ordy, input logic efr, input logic eiv,
                       input logic err, input logic eov, input logic [31:0] epc,
                       input logic [31:0] einst);
        vec_t v;
        v = '{fv, pc, 1'b1, rv, rd, sq, ordy, efr, eiv, err, eov, epc, einst};
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5a5a_0013;
    endfunction

    task automatic run_vectors();
        // straight-line fetch, memory latency 1
        add(1, 32'h200, 0, 0,             0, 1,  1, 1, 0, 0, 0,      0);
        add(1, 32'h204, 1, 32'h0000_0013, 0, 1,  1, 1, 1, 0, 0,      0);
        add(1, 32'h208, 1, 32'h0040_0093, 0, 1,  0, 0, 1, 1, 32'h200, 32'h0000_0013);
        add(1, 32'h208, 0, 0,             0, 1,  1, 1, 0, 1, 32'h204, 32'h0040_0093);
        add(0, 0,       1, 32'h0080_0113, 0, 1,  1, 0, 1, 0, 0,      0);
        add(0, 0,       0, 0,             0, 1,  1, 0, 0, 1, 32'h208, 32'h0080_0113);
        add(0, 0,       0, 0,             0, 1,  1, 0, 0, 0, 0,      0);
        // full buffer with decode stalled, then drained
        add(1, 32'h200, 0, 0,             0, 0,  1, 1, 0, 0, 0,      0);
        add(1, 32'h204, 1, 32'h0000_0013, 0, 0,  1, 1, 1, 0, 0,      0);
        add(1, 32'h208, 1, 32'h0040_0093, 0, 0,  0, 0, 1, 1, 32'h200, 32'h0000_0013);
        add(1, 32'h208, 0, 0,             0, 0,  0, 0, 0, 1, 32'h200, 32'h0000_0013);
        add(1, 32'h208, 0, 0,             0, 1,  0, 0, 0, 1, 32'h200, 32'h0000_0013);
        add(1, 32'h208, 0, 0,             0, 1,  1, 1, 0, 1, 32'h204, 32'h0040_0093);
        add(0, 0,       1, 32'h0080_0113, 0, 1,  1, 0, 1, 0, 0,      0);
        add(0, 0,       0, 0,             0, 1,  1, 0, 0, 1, 32'h208, 32'h0080_0113);
        // squash with two fetches awaiting data
        add(1, 32'h200, 0, 0,             0, 1,  1, 1, 0, 0, 0,      0);
        add(1, 32'h204, 1, 32'h0000_0013, 0, 1,  1, 1, 1, 0, 0,      0);
        add(0, 0,       0, 0,             0, 1,  0, 0, 1, 1, 32'h200, 32'h0000_0013);
        add(1, 32'h208, 0, 0,             0, 1,  1, 1, 1, 0, 0,      0);
        add(1, 32'h300, 0, 0,             1, 1,  0, 0, 1, 0, 0,      0);
        add(1, 32'h300, 1, 32'hbad0_0001, 0, 1,  0, 0, 1, 0, 0,      0);
        add(1, 32'h300, 1, 32'hbad0_0002, 0, 1,  0, 0, 1, 0, 0,      0);
        add(1, 32'h300, 0, 0,             0, 1,  1, 1, 0, 0, 0,      0);
        add(0, 0,       1, 32'h0000_0317, 0, 1,  1, 0, 1, 0, 0,      0);
        add(0, 0,       0, 0,             0, 1,  1, 0, 0, 1, 32'h300, 32'h0000_0317);
        // squash in the cycle the old fetch's data arrives, redirect target issued alongside
        add(1, 32'h400, 0, 0,             0, 1,  1, 1, 0, 0, 0,      0);
        add(1, 32'h500, 1, 32'hbad0_0400, 1, 1,  1, 1, 1, 0, 0,      0);
        add(0, 0,       1, 32'h0000_0517, 0, 1,  0, 0, 1, 0, 0,      0);
        add(0, 0,       0, 0,             0, 1,  1, 0, 0, 1, 32'h500, 32'h0000_0517);
        // squash while head data is valid and decode is ready
        add(1, 32'h600, 0, 0,             0, 1,  1, 1, 0, 0, 0,      0);
        add(0, 0,       1, 32'hbad0_0600, 0, 1,  1, 0, 1, 0, 0,      0);
        add(0, 0,       0, 0,             1, 1,  1, 0, 0, 0, 0,      0);
        add(0, 0,       0, 0,             0, 1,  1, 0, 0, 0, 0,      0);
        add(0, 0,       0, 0,             0, 1,  1, 0, 0, 0, 0,      0);

        foreach (vecs[i]) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].mrdy, vecs[i].rv, vecs[i].rd, vecs[i].sq,
                  vecs[i].ordy);
            @(negedge clk);
            check($sformatf("vec%0d fetch_rdy", i), 32'(bus.fetch_rdy), 32'(vecs[i].e_frdy));
            check($sformatf("vec%0d imemreq_val", i), 32'(bus.imemreq_val), 32'(vecs[i].e_ival));
            check($sformatf("vec%0d imemresp_rdy", i), 32'(bus.imemresp_rdy), 32'(vecs[i].e_rrdy));
            check($sformatf("vec%0d out_val", i), 32'(bus.out_val), 32'(vecs[i].e_oval));
            if (vecs[i].e_ival) begin
                check($sformatf("vec%0d imemreq_addr", i), bus.imemreq_addr, vecs[i].pc);
            end
            if (vecs[i].e_oval) begin
                check($sformatf("vec%0d out_pc", i), bus.out_pc, vecs[i].e_pc);
                check($sformatf("vec%0d out_inst", i), bus.out_inst, vecs[i].e_inst);
            end
            next_cycle();
        end
    endtask

    task automatic run_reset_mid();
        drive(1, 32'h200, 1, 0, 0, 0, 1);
        next_cycle();
        drive(1, 32'h204, 1, 0, 0, 0, 1);
        next_cycle();
        drive(1, 32'h208, 1, 0, 0, 0, 1);
        #1 reset = 1'b0;
        #1;
        check("rst_mid out_val", 32'(bus.out_val), 32'd0);
        check("rst_mid fetch_rdy", 32'(bus.fetch_rdy), 32'd0);
        check("rst_mid imemreq_val", 32'(bus.imemreq_val), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 1, 1, 32'hdead_beef, 0, 1);
        #1;
        check("rst_rel stale imemresp_rdy", 32'(bus.imemresp_rdy), 32'd0);
        check("rst_rel fetch_rdy", 32'(bus.fetch_rdy), 32'd1);
        next_cycle();
        drive(0, 0, 1, 1, 32'hdead_beef, 0, 1);
        @(negedge clk);
        check("rst_rel out_val", 32'(bus.out_val), 32'd0);
        check("rst_rel imemresp_rdy", 32'(bus.imemresp_rdy), 32'd0);
        next_cycle();
    endtask

    task automatic run_latency();
        drive(1, 32'h800, 1, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 1, 1, 32'h0000_0013, 0, 1);
        @(negedge clk);
`ifdef FETCH_RESP_BUFFER_BYPASS_EN
        check("lat resp-cycle out_val", 32'(bus.out_val), 32'd1);
        check("lat resp-cycle out_inst", bus.out_inst, 32'h0000_0013);
        check("lat resp-cycle out_pc", bus.out_pc, 32'h800);
`else
        check("lat resp-cycle out_val", 32'(bus.out_val), 32'd0);
`endif
        next_cycle();
        drive(0, 0, 1, 0, 0, 0, 1);
        @(negedge clk);
`ifdef FETCH_RESP_BUFFER_BYPASS_EN
        check("lat next out_val", 32'(bus.out_val), 32'd0);
`else
        check("lat next out_val", 32'(bus.out_val), 32'd1);
        check("lat next out_inst", bus.out_inst, 32'h0000_0013);
        check("lat next out_pc", bus.out_pc, 32'h800);
`endif
        next_cycle();
        @(negedge clk);
        check("lat drained out_val", 32'(bus.out_val), 32'd0);
        check("lat drained fetch_rdy", 32'(bus.fetch_rdy), 32'd1);
        next_cycle();
    endtask

    task automatic run_random(input int ncycles);
        ment_t       mq[$];
        logic [31:0] memq[$];
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            logic        fv, mrdy, rv, sq, ordy;
            logic [31:0] pc, rd;
            bit          full, e_frdy, e_ival, e_rrdy, e_oval, byp, retire_head, resp_acc;
            logic [31:0] e_pc, e_inst;
            int          widx;
            ment_t       ne;

            fv   = $urandom_range(0, 9) < 7;
            pc   = $urandom & 32'hffff_fffc;
            mrdy = $urandom_range(0, 9) < 8;
            sq   = $urandom_range(0, 11) == 0;
            ordy = $urandom_range(0, 9) < 7;
            if (memq.size() > 0) begin
                rv = $urandom_range(0, 9) < 6;
                rd = inst_of(memq[0]);
            end else begin
                rv = $urandom_range(0, 19) == 0;
                rd = $urandom;
            end
            drive(fv, pc, mrdy, rv, rd, sq, ordy);

            full   = mq.size() == c_depth;
            widx   = -1;
            foreach (mq[k]) if (!mq[k].has_data && widx < 0) widx = k;
            e_frdy = mrdy && !full;
            e_ival = fv && !full;
            e_rrdy = widx >= 0;
            e_oval = 0;
            e_pc   = '0;
            e_inst = '0;
            byp    = 0;
            if (mq.size() > 0) begin
                e_oval = mq[0].has_data && !mq[0].sq && !sq;
                e_pc   = mq[0].pc;
                e_inst = mq[0].inst;
`ifdef FETCH_RESP_BUFFER_BYPASS_EN
                if (!mq[0].has_data && !mq[0].sq && rv && !sq) begin
                    byp    = 1;
                    e_oval = 1;
                    e_inst = rd;
                end
`endif
            end

            @(negedge clk);
            check($sformatf("rnd%0d fetch_rdy", cyc), 32'(bus.fetch_rdy), 32'(e_frdy));
            check($sformatf("rnd%0d imemreq_val", cyc), 32'(bus.imemreq_val), 32'(e_ival));
            check($sformatf("rnd%0d imemresp_rdy", cyc), 32'(bus.imemresp_rdy), 32'(e_rrdy));
            check($sformatf("rnd%0d out_val", cyc), 32'(bus.out_val), 32'(e_oval));
            if (e_ival) check($sformatf("rnd%0d imemreq_addr", cyc), bus.imemreq_addr, pc);
            if (e_oval) begin
                check($sformatf("rnd%0d out_pc", cyc), bus.out_pc, e_pc);
                check($sformatf("rnd%0d out_inst", cyc), bus.out_inst, e_inst);
            end

            retire_head = (mq.size() > 0) && mq[0].has_data && (mq[0].sq || (e_oval && ordy));
            resp_acc    = rv && e_rrdy;
            if (resp_acc) void'(memq.pop_front());
            if (resp_acc && !(byp && ordy)) begin
                mq[widx].has_data = 1;
                mq[widx].inst     = rd;
            end
            if ((byp && ordy) || retire_head) void'(mq.pop_front());
            if (sq) foreach (mq[k]) mq[k].sq = 1;
            if (fv && e_frdy) begin
                ne = '{pc, 32'd0, 1'b0, 1'b0};
                mq.push_back(ne);
                memq.push_back(pc);
            end
            next_cycle();
        end
    endtask

    initial begin
        drive(1, 32'h100, 1, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset fetch_rdy", 32'(bus.fetch_rdy), 32'd0);
        check("reset imemreq_val", 32'(bus.imemreq_val), 32'd0);
        check("reset imemresp_rdy", 32'(bus.imemresp_rdy), 32'd0);
        check("reset out_val", 32'(bus.out_val), 32'd0);
        check("reset out_pc", bus.out_pc, 32'd0);
        check("reset out_inst", bus.out_inst, 32'd0);
        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 0, 1);
        next_cycle();

`ifndef FETCH_RESP_BUFFER_BYPASS_EN
        run_vectors();
`endif
        run_reset_mid();
        run_latency();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
